// File: rtl/tag_gen_arbiter_pkg.sv
// tag_pkg: constants and types shared by the tag_gen_arbiter block and
// the tag_generation engine it fronts.
//   DATA_W     : engine data width
//   TAG_W      : engine tag width
//   ENGINE_LAT : default engine latency in clock edges
//   state_t    : arbiter FSM states
package tag_pkg;

  localparam int DATA_W     = 32;
  localparam int TAG_W      = 8;
  localparam int ENGINE_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/tag_gen_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin grant selection.
//   req       : request vector, one bit per requester
//   ptr       : index that has highest priority this round
//   grant     : one-hot grant, zero when no request is set
//   grant_idx : binary index of the granted requester
//   any_req   : at least one request bit is set
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_req
);

  logic           found;
  logic [PTR_W:0] pos;
  logic [PTR_W-1:0] idx;

  // Scan ptr, ptr+1, ... with wrap; the first set bit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(NUM_REQ)) begin
        pos = pos - (PTR_W+1)'(NUM_REQ);
      end
      idx = pos[PTR_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/tag_gen_arbiter.sv
// tag_gen_arbiter: shares one registered tag_generation engine among
// NUM_REQ requesters, one transaction in flight at a time.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   req_valid  : per-requester request valid
//   req_data   : packed request data, requester i at [i*DATA_W +: DATA_W]
//   req_ready  : one-hot accept, only in IDLE
//   rsp_valid  : one-hot response valid for the originating requester
//   rsp_ready  : per-requester response accept
//   rsp_tag    : returned tag, qualified by rsp_valid
//   eng_data   : data driven to the engine, held for the whole transaction
//   eng_tag    : tag returned by the engine
//   busy       : high whenever the FSM is not IDLE
module tag_gen_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = tag_pkg::DATA_W,
  parameter int TAG_W      = tag_pkg::TAG_W,
  parameter int ENGINE_LAT = tag_pkg::ENGINE_LAT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [TAG_W-1:0]          rsp_tag,
  output logic [DATA_W-1:0]         eng_data,
  input  logic [TAG_W-1:0]          eng_tag,
  output logic                      busy
);

  import tag_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 4;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   id;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               any_req;
  logic               req_hs;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  assign req_ready = (state == ST_IDLE && any_req) ? grant : '0;
  assign req_hs    = |(req_valid & req_ready);
  assign rsp_valid = (state == ST_RESP) ? (NUM_REQ'(1) << id) : '0;
  assign busy      = (state != ST_IDLE);

  // cnt is loaded with ENGINE_LAT and the tag is captured on the edge
  // where it has reached zero, i.e. ENGINE_LAT+1 edges after the grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      id       <= '0;
      cnt      <= '0;
      eng_data <= '0;
      rsp_tag  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_hs) begin
            eng_data <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
            id       <= grant_idx;
            cnt      <= CNT_W'(ENGINE_LAT);
            rr_ptr   <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            rsp_tag <= eng_tag;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready[id]) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_gen_arbiter.sv
// tb_tag_gen_arbiter: directed scoreboard bench for tag_gen_arbiter.
// A registered engine stub returns eng_data[7:0] one edge later.
// Stimulus pushes expected grants and responses into queues; a monitor
// pops and compares on every request and response handshake.
module tb_tag_gen_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 32;
  localparam int TAG_W      = 8;
  localparam int ENGINE_LAT = 1;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [TAG_W-1:0]          rsp_tag;
  logic [DATA_W-1:0]         eng_data;
  logic [TAG_W-1:0]          eng_tag = '0;
  logic                      busy;

  typedef struct {
    int         id;
    logic [7:0] tag;
  } rsp_exp_t;

  rsp_exp_t exp_rsp[$];
  int       exp_grant[$];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;

  tag_gen_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .TAG_W      (TAG_W),
    .ENGINE_LAT (ENGINE_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_tag   (rsp_tag),
    .eng_data  (eng_data),
    .eng_tag   (eng_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    eng_tag <= eng_data[7:0];
    cyc     <= cyc + 1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Monitor: grants, response order/content, latency and stall stability.
  logic               prev_valid = 1'b0;
  logic               prev_acc   = 1'b0;
  logic [NUM_REQ-1:0] prev_rsp_valid = '0;
  logic [TAG_W-1:0]   prev_tag = '0;
  logic               hs_pending = 1'b0;
  int                 hs_cyc = 0;

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] hs;
    logic [NUM_REQ-1:0] acc;
    rsp_exp_t           e;
    if (!reset) begin
      prev_valid = 1'b0;
      prev_acc   = 1'b0;
      hs_pending = 1'b0;
    end else begin
      hs = req_valid & req_ready;
      if (hs != '0) begin
        check_output("req_ready_onehot", $countones(req_ready), 1);
        if (exp_grant.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_grant: got %0d, expected none", onehot_idx(hs));
        end else begin
          check_output("grant_idx", onehot_idx(hs), exp_grant.pop_front());
        end
        hs_cyc     = cyc;
        hs_pending = 1'b1;
      end
      if (prev_valid && !prev_acc) begin
        check_output("rsp_valid_stall", rsp_valid, prev_rsp_valid);
        check_output("rsp_tag_stall", rsp_tag, prev_tag);
      end
      if (rsp_valid != '0) begin
        if (!prev_valid && hs_pending) begin
          check_output("rsp_latency", cyc - hs_cyc, ENGINE_LAT + 2);
          hs_pending = 1'b0;
        end
        acc = rsp_valid & rsp_ready;
        if (acc != '0) begin
          check_output("rsp_valid_onehot", $countones(rsp_valid), 1);
          if (exp_rsp.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp: got id %0d tag 0x%0h, expected none", onehot_idx(acc), rsp_tag);
          end else begin
            e = exp_rsp.pop_front();
            check_output("rsp_id", onehot_idx(acc), e.id);
            check_output("rsp_tag", rsp_tag, e.tag);
          end
        end
      end
      prev_valid     = |rsp_valid;
      prev_rsp_valid = rsp_valid;
      prev_tag       = rsp_tag;
      prev_acc       = |(rsp_valid & rsp_ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int idx, input logic [31:0] data);
    req_data[idx*DATA_W +: DATA_W] = data;
  endtask

  task automatic push_txn(input int idx, input logic [7:0] tag);
    rsp_exp_t e;
    e.id  = idx;
    e.tag = tag;
    exp_grant.push_back(idx);
    exp_rsp.push_back(e);
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      check_output("reset_req_ready", req_ready, 0);
      check_output("reset_rsp_valid", rsp_valid, 0);
      check_output("reset_rsp_tag", rsp_tag, 0);
      check_output("reset_eng_data", eng_data, 0);
      check_output("reset_busy", busy, 0);
    end
    tick();
    reset = 1'b1;
  endtask

  // Each requester in mask drops req_valid right after its own grant edge.
  task automatic run_requests(input logic [NUM_REQ-1:0] mask, input int bound);
    logic [NUM_REQ-1:0] hs;
    int n = 0;
    req_valid = req_valid | mask;
    while ((req_valid & mask) != '0 && n < bound) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      tick();
      req_valid = req_valid & ~hs;
      n++;
    end
    if ((req_valid & mask) != '0) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout: pending 0x%0h, required 0x0", req_valid & mask);
      req_valid = req_valid & ~mask;
    end
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (exp_rsp.size() != 0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_rsp.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d responses outstanding, required 0", exp_rsp.size());
      exp_rsp.delete();
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hcount;
    int n;
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = '0;

    // Reset then idle.
    apply_reset(2);
    @(negedge clk);
    check_output("idle_busy", busy, 0);
    check_output("idle_req_ready", req_ready, 0);
    check_output("idle_rsp_valid", rsp_valid, 0);
    tick();

    // Single request from requester 0.
    $display("[TB] single request");
    rsp_ready = '1;
    apply_stimulus(0, 32'h12345678);
    push_txn(0, 8'h78);
    req_valid = 4'b0001;
    @(negedge clk);
    check_output("single_req_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    check_output("single_eng_data", eng_data, 32'h12345678);
    check_output("single_busy", busy, 1);
    wait_drain(20);
    @(negedge clk);
    check_output("busy_after_accept", busy, 0);
    tick();

    // Round robin from a fresh pointer: two full rounds.
    $display("[TB] round robin");
    apply_reset(2);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        push_txn(i, 8'h21 + 8'(i));
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      apply_stimulus(i, 32'h87654321 + 32'(i));
    end
    req_valid = '1;
    hcount = 0;
    n = 0;
    while (hcount < 2*NUM_REQ && n < 200) begin
      @(negedge clk);
      if ((req_valid & req_ready) != '0) hcount++;
      n++;
    end
    tick();
    req_valid = '0;
    check_output("rr_grant_count", hcount, 2*NUM_REQ);
    wait_drain(50);

    // Response backpressure on requester 2 while requester 1 waits.
    $display("[TB] backpressure");
    rsp_ready = 4'b1011;
    apply_stimulus(2, 32'h000000AB);
    push_txn(2, 8'hAB);
    run_requests(4'b0100, 10);
    n = 0;
    while (!rsp_valid[2] && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_output("bp_rsp_valid_seen", rsp_valid, 4'b0100);
    tick();
    apply_stimulus(1, 32'h00000055);
    push_txn(1, 8'h55);
    req_valid = 4'b0010;
    repeat (5) begin
      @(negedge clk);
      check_output("bp_rsp_valid_hold", rsp_valid, 4'b0100);
      check_output("bp_rsp_tag_hold", rsp_tag, 8'hAB);
      check_output("bp_req_ready_blocked", req_ready, 0);
    end
    tick();
    rsp_ready = '1;
    run_requests(4'b0010, 10);
    wait_drain(20);

    // Pointer wrap: 3 alone, then 0 and 3 together.
    $display("[TB] pointer wrap");
    apply_stimulus(3, 32'hCAFE00C3);
    push_txn(3, 8'hC3);
    run_requests(4'b1000, 10);
    wait_drain(20);
    apply_stimulus(0, 32'h0BADF00D);
    push_txn(0, 8'h0D);
    push_txn(3, 8'hC3);
    run_requests(4'b1001, 20);
    wait_drain(20);

    // Reset during WAIT drops the transaction and restarts rr_ptr at 0.
    $display("[TB] reset mid-operation");
    apply_stimulus(1, 32'h00000077);
    exp_grant.push_back(1);
    run_requests(4'b0010, 10);
    check_output("mid_busy_before_reset", busy, 1);
    apply_reset(2);
    repeat (4) begin
      @(negedge clk);
      check_output("no_rsp_after_reset", rsp_valid, 0);
    end
    tick();
    apply_stimulus(1, 32'h11111111);
    apply_stimulus(2, 32'h22222222);
    push_txn(1, 8'h11);
    push_txn(2, 8'h22);
    run_requests(4'b0110, 20);
    wait_drain(30);

    check_output("grant_queue_empty", exp_grant.size(), 0);
    check_output("rsp_queue_empty", exp_rsp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
